// File: rtl/ir_nec_rx_gen2_if.sv
`default_nettype none
// ============================================================================
// Module      : ir_nec_rx_gen2_if
// Description : Output bus of the NEC IR receiver. It carries the decoded
//               frame with a valid/ready handshake and three event pulses.
// Revision    : 1.0 - initial release
// ============================================================================
interface ir_nec_rx_gen2_if;
   logic [31:0] oDATA;
   logic        oVALID;
   logic        iREADY;
   logic        oREPEAT;
   logic        oERR;
   logic        oOVERRUN;

   // The receiver drives the frame, the handshake valid and the event pulses.
   modport master (
      output oDATA,
      output oVALID,
      output oREPEAT,
      output oERR,
      output oOVERRUN,
      input  iREADY
   );

   // The command consumer accepts frames.
   modport slave (
      input  oDATA,
      input  oVALID,
      input  oREPEAT,
      input  oERR,
      input  oOVERRUN,
      output iREADY
   );
endinterface
`default_nettype wire

// File: rtl/ir_nec_rx_gen2.sv
`default_nettype none
// ============================================================================
// Module      : ir_nec_rx_gen2
// Description : NEC infrared frame decoder. It takes the raw demodulator pin
//               (active-low mark), synchronises and deglitches it, and times
//               each level run against tolerance windows. Frames are
//               delivered through a valid/ready bus.
//               Build option: define IR_REPEAT_EN to decode repeat codes.
// Revision    : 1.0 - initial release
// ============================================================================
module ir_nec_rx_gen2 #(
   parameter int CLK_HZ     = 50_000_000,
   parameter int TOL_PCT    = 25,
   parameter int FILT_LEN   = 4,
   parameter int ADDR_CHK   = 0,
   parameter int REP_WIN_US = 110000
) (
   input wire                iCLK,
   input wire                iRST_n,   // synchronous, active-high
   input wire                iIRDA,
   ir_nec_rx_gen2_if.master  bus
);

   // Convert microseconds to clock cycles.
   function automatic logic [63:0] f_cyc(input logic [63:0] us);
      return (us * 64'(CLK_HZ)) / 64'd1_000_000;
   endfunction

   function automatic logic [63:0] f_lo(input logic [63:0] us);
      return (f_cyc(us) * 64'(100 - TOL_PCT)) / 64'd100;
   endfunction

   function automatic logic [63:0] f_hi(input logic [63:0] us);
      return (f_cyc(us) * 64'(100 + TOL_PCT)) / 64'd100;
   endfunction

   localparam logic [63:0] c_rep_cyc = f_cyc(64'(REP_WIN_US));
   localparam int          c_cnt_w   = $clog2(c_rep_cyc) + 1;
   localparam int          c_fw      = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

   localparam logic [63:0] c_lm_lo = f_lo(64'd9000);
   localparam logic [63:0] c_lm_hi = f_hi(64'd9000);
   localparam logic [63:0] c_ls_lo = f_lo(64'd4500);
   localparam logic [63:0] c_ls_hi = f_hi(64'd4500);
   localparam logic [63:0] c_bm_lo = f_lo(64'd560);
   localparam logic [63:0] c_bm_hi = f_hi(64'd560);
   localparam logic [63:0] c_b1_lo = f_lo(64'd1690);
   localparam logic [63:0] c_b1_hi = f_hi(64'd1690);

   typedef enum logic [3:0] {
      S_IDLE       = 4'd0,
      S_LEAD_MARK  = 4'd1,
      S_LEAD_SPACE = 4'd2,
      S_BIT_MARK   = 4'd3,
      S_BIT_SPACE  = 4'd4,
      S_STOP_MARK  = 4'd5,
      S_REP_MARK   = 4'd6,
      S_CHECK      = 4'd7,
      S_ERR        = 4'd8
   } state_t;

   logic [1:0]         sync_q;
   logic               filt_q;
   logic               filt_prev_q;
   logic [c_fw-1:0]    fcnt_q;
   logic [c_cnt_w-1:0] seg_cnt_q;
   state_t             state_q;
   logic [4:0]         bit_idx_q;
   logic [31:0]        shift_q;
   logic [31:0]        data_q;
   logic               valid_q;
   logic               err_q;
   logic               ovr_q;

   logic        w_fall;
   logic        w_rise;
   logic        w_sat;
   logic        w_timeout;
   logic [63:0] w_len;
   logic        w_ok_lm;
   logic        w_ok_ls;
   logic        w_ok_bm;
   logic        w_ok_b1;
   logic        w_sum_ok;

   assign w_fall    = filt_prev_q & ~filt_q;
   assign w_rise    = ~filt_prev_q & filt_q;
   assign w_sat     = &seg_cnt_q;
   assign w_len     = 64'(seg_cnt_q);
   assign w_ok_lm   = (w_len >= c_lm_lo) && (w_len <= c_lm_hi);
   assign w_ok_ls   = (w_len >= c_ls_lo) && (w_len <= c_ls_hi);
   assign w_ok_bm   = (w_len >= c_bm_lo) && (w_len <= c_bm_hi);
   assign w_ok_b1   = (w_len >= c_b1_lo) && (w_len <= c_b1_hi);
   // A segment stuck with no edge for the whole repeat window aborts a frame.
   assign w_timeout = w_sat && (state_q != S_IDLE) && (state_q != S_CHECK) &&
                      (state_q != S_ERR);
   assign w_sum_ok  = (shift_q[31:24] == ~shift_q[23:16]) &&
                      ((ADDR_CHK == 0) || (shift_q[15:8] == ~shift_q[7:0]));

`ifdef IR_REPEAT_EN
   localparam logic [63:0]        c_rs_lo   = f_lo(64'd2250);
   localparam logic [63:0]        c_rs_hi   = f_hi(64'd2250);
   localparam logic [c_cnt_w-1:0] c_rep_lim = c_cnt_w'(c_rep_cyc);

   logic               rep_q;
   logic [c_cnt_w-1:0] rep_cnt_q;
   logic               rep_live_q;
   logic               w_ok_rs;
   logic               w_check_pass;

   assign w_ok_rs      = (w_len >= c_rs_lo) && (w_len <= c_rs_hi);
   assign w_check_pass = (state_q == S_CHECK) && w_sum_ok;

   // Time since the last good frame; repeats are honoured while still live.
   always_ff @(posedge iCLK) begin
      if (iRST_n) begin
         rep_cnt_q  <= '0;
         rep_live_q <= 1'b0;
      end else if (w_check_pass) begin
         rep_cnt_q  <= '0;
         rep_live_q <= 1'b1;
      end else if (rep_live_q) begin
         if (rep_cnt_q >= c_rep_lim) begin
            rep_live_q <= 1'b0;
         end else begin
            rep_cnt_q <= rep_cnt_q + c_cnt_w'(1);
         end
      end
   end

   assign bus.oREPEAT = rep_q;
`else
   assign bus.oREPEAT = 1'b0;
`endif

   // Synchronise the pin, then accept a new level only after FILT_LEN equal samples.
   always_ff @(posedge iCLK) begin
      if (iRST_n) begin
         sync_q      <= 2'b11;
         filt_q      <= 1'b1;
         filt_prev_q <= 1'b1;
         fcnt_q      <= '0;
      end else begin
         sync_q      <= {sync_q[0], iIRDA};
         filt_prev_q <= filt_q;
         if (sync_q[1] == filt_q) begin
            fcnt_q <= '0;
         end else if (fcnt_q == c_fw'(FILT_LEN - 1)) begin
            filt_q <= sync_q[1];
            fcnt_q <= '0;
         end else begin
            fcnt_q <= fcnt_q + c_fw'(1);
         end
      end
   end

   // Length of the current filtered level run, saturating at all-ones.
   always_ff @(posedge iCLK) begin
      if (iRST_n) begin
         seg_cnt_q <= '0;
      end else if (w_fall || w_rise) begin
         seg_cnt_q <= c_cnt_w'(1);
      end else if (!w_sat) begin
         seg_cnt_q <= seg_cnt_q + c_cnt_w'(1);
      end
   end

   // Frame decoder: each segment is judged on the edge that ends it.
   always_ff @(posedge iCLK) begin
      if (iRST_n) begin
         state_q   <= S_IDLE;
         bit_idx_q <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
         ovr_q     <= 1'b0;
`ifdef IR_REPEAT_EN
         rep_q     <= 1'b0;
`endif
      end else begin
         err_q <= 1'b0;
         ovr_q <= 1'b0;
`ifdef IR_REPEAT_EN
         rep_q <= 1'b0;
`endif
         if (valid_q && bus.iREADY) begin
            valid_q <= 1'b0;
         end
         if (w_timeout) begin
            state_q <= S_ERR;
            err_q   <= 1'b1;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (w_fall) state_q <= S_LEAD_MARK;
               end
               S_LEAD_MARK: begin
                  if (w_rise) begin
                     if (w_ok_lm) begin
                        state_q <= S_LEAD_SPACE;
                     end else begin
                        state_q <= S_ERR;
                        err_q   <= 1'b1;
                     end
                  end
               end
               S_LEAD_SPACE: begin
                  if (w_fall) begin
                     if (w_ok_ls) begin
                        state_q   <= S_BIT_MARK;
                        bit_idx_q <= '0;
                     end
`ifdef IR_REPEAT_EN
                     else if (w_ok_rs) begin
                        state_q <= S_REP_MARK;
                     end
`endif
                     else begin
                        state_q <= S_ERR;
                        err_q   <= 1'b1;
                     end
                  end
               end
               S_BIT_MARK: begin
                  if (w_rise) begin
                     if (w_ok_bm) begin
                        state_q <= S_BIT_SPACE;
                     end else begin
                        state_q <= S_ERR;
                        err_q   <= 1'b1;
                     end
                  end
               end
               S_BIT_SPACE: begin
                  if (w_fall) begin
                     if (w_ok_bm || w_ok_b1) begin
                        // Bits arrive LSB first, so shift in from the top.
                        shift_q <= {w_ok_b1, shift_q[31:1]};
                        if (bit_idx_q == 5'd31) begin
                           state_q <= S_STOP_MARK;
                        end else begin
                           bit_idx_q <= bit_idx_q + 5'd1;
                           state_q   <= S_BIT_MARK;
                        end
                     end else begin
                        state_q <= S_ERR;
                        err_q   <= 1'b1;
                     end
                  end
               end
               S_STOP_MARK: begin
                  if (w_rise) begin
                     if (w_ok_bm) begin
                        state_q <= S_CHECK;
                     end else begin
                        state_q <= S_ERR;
                        err_q   <= 1'b1;
                     end
                  end
               end
`ifdef IR_REPEAT_EN
               S_REP_MARK: begin
                  if (w_rise) begin
                     if (w_ok_bm) begin
                        state_q <= S_IDLE;
                        rep_q   <= rep_live_q;
                     end else begin
                        state_q <= S_ERR;
                        err_q   <= 1'b1;
                     end
                  end
               end
`endif
               S_CHECK: begin
                  if (w_sum_ok) begin
                     state_q <= S_IDLE;
                     // A consume in this same cycle frees the slot for the new frame.
                     if (!valid_q || bus.iREADY) begin
                        data_q  <= shift_q;
                        valid_q <= 1'b1;
                     end else begin
                        ovr_q <= 1'b1;
                     end
                  end else begin
                     state_q <= S_ERR;
                     err_q   <= 1'b1;
                  end
               end
               S_ERR: begin
                  state_q <= S_IDLE;
               end
               default: begin
                  state_q <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign bus.oDATA    = data_q;
   assign bus.oVALID   = valid_q;
   assign bus.oERR     = err_q;
   assign bus.oOVERRUN = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_ir_nec_rx_gen2.sv
`default_nettype none
// ============================================================================
// Module      : tb_ir_nec_rx_gen2
// Description : Self-checking bench for ir_nec_rx_gen2. Two receivers share
//               one IR pin: one with 16-bit extended address, one with the
//               address/inverse check. Outcomes are predicted from segment
//               durations and the frame checksum rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ir_nec_rx_gen2;

   localparam int CLK_HZ     = 50_000;
   localparam int TOL        = 25;
   localparam int US_PER_CYC = 1_000_000 / CLK_HZ;

   logic clk;
   logic rst;
   logic pin;
   logic rdy;

   ir_nec_rx_gen2_if bus0 ();
   ir_nec_rx_gen2_if bus1 ();

   assign bus0.iREADY = rdy;
   assign bus1.iREADY = rdy;

   ir_nec_rx_gen2 #(.CLK_HZ(CLK_HZ), .TOL_PCT(TOL), .FILT_LEN(4), .ADDR_CHK(0),
                    .REP_WIN_US(110000))
   dut (.iCLK(clk), .iRST_n(rst), .iIRDA(pin), .bus(bus0));

   ir_nec_rx_gen2 #(.CLK_HZ(CLK_HZ), .TOL_PCT(TOL), .FILT_LEN(4), .ADDR_CHK(1),
                    .REP_WIN_US(110000))
   dut_ac (.iCLK(clk), .iRST_n(rst), .iIRDA(pin), .bus(bus1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Observed events per receiver.
   logic [31:0] q0[$];
   logic [31:0] q1[$];
   int err0 = 0, err1 = 0, rep0 = 0, ovr0 = 0, vcyc0 = 0;

   // Collect consumed frames and event pulses away from the clock edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus0.oVALID && rdy) q0.push_back(bus0.oDATA);
         if (bus1.oVALID && rdy) q1.push_back(bus1.oDATA);
         if (bus0.oVALID) vcyc0++;
         if (bus0.oERR) err0++;
         if (bus1.oERR) err1++;
         if (bus0.oREPEAT) rep0++;
         if (bus0.oOVERRUN) ovr0++;
      end
   end

   // ---------------- reference model helpers ----------------
   function automatic bit in_tol(input int act, input int nom);
      return (act * 100 >= nom * (100 - TOL)) && (act * 100 <= nom * (100 + TOL));
   endfunction

   function automatic int jitter(input int nom, input int pct);
      int j;
      if (pct == 0) return nom;
      j = int'($urandom_range(2 * pct, 0)) - pct;
      return nom * (100 + j) / 100;
   endfunction

   function automatic bit frame_ok(input logic [31:0] w, input bit addr_chk);
      logic [7:0] a, an, c, cn;
      {cn, c, an, a} = w;
      return (cn == ~c) && (!addr_chk || an == ~a);
   endfunction

   // ---------------- stimulus ----------------
   task automatic seg(input logic lvl, input int act_us, input bit gl);
      int cyc;
      cyc = act_us / US_PER_CYC;
      pin = lvl;
      if (gl) begin
         repeat (cyc / 2) @(negedge clk);
         pin = ~lvl;
         repeat (3) @(negedge clk);
         pin = lvl;
         repeat (cyc - cyc / 2 - 3) @(negedge clk);
      end else begin
         repeat (cyc) @(negedge clk);
      end
   endtask

   task automatic send_frame(input logic [31:0] w, input int jit, input bit gl,
                             input int bad_bit, input int bad_us, output bit ok);
      int a;
      int nom;
      ok = 1'b1;
      a = jitter(9000, jit); ok &= in_tol(a, 9000); seg(1'b0, a, gl);
      a = jitter(4500, jit); ok &= in_tol(a, 4500); seg(1'b1, a, gl);
      for (int i = 0; i < 32; i++) begin
         a = jitter(560, jit); ok &= in_tol(a, 560); seg(1'b0, a, gl);
         if (i == bad_bit) begin
            ok &= in_tol(bad_us, 560) | in_tol(bad_us, 1690);
            seg(1'b1, bad_us, gl);
            seg(1'b0, 560, 1'b0);
            pin = 1'b1;
            repeat (60) @(negedge clk);
            return;
         end
         nom = w[i] ? 1690 : 560;
         a = jitter(nom, jit); ok &= in_tol(a, nom); seg(1'b1, a, gl);
      end
      a = jitter(560, jit); ok &= in_tol(a, 560); seg(1'b0, a, gl);
      pin = 1'b1;
      repeat (60) @(negedge clk);
   endtask

   task automatic send_repeat();
      seg(1'b0, 9000, 1'b0);
      seg(1'b1, 2250, 1'b0);
      seg(1'b0, 560, 1'b0);
      pin = 1'b1;
      repeat (60) @(negedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      int e0;
      rst = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_chk++;
      if ({bus0.oDATA, bus0.oVALID, bus0.oERR, bus0.oREPEAT, bus0.oOVERRUN} !== 36'd0)
         $display("FAIL reset_outs0: got %h want 0",
                  {bus0.oDATA, bus0.oVALID, bus0.oERR, bus0.oREPEAT, bus0.oOVERRUN});
      else n_pass++;
      n_chk++;
      if ({bus1.oDATA, bus1.oVALID, bus1.oERR, bus1.oREPEAT, bus1.oOVERRUN} !== 36'd0)
         $display("FAIL reset_outs1: got %h want 0",
                  {bus1.oDATA, bus1.oVALID, bus1.oERR, bus1.oREPEAT, bus1.oOVERRUN});
      else n_pass++;
      e0 = err0;
      repeat (1000) @(negedge clk);
      n_chk++;
      if (err0 !== e0) $display("FAIL reset_idle_err: got %0d want %0d", err0, e0);
      else n_pass++;
   endtask

   task automatic test_basic();
      bit ok;
      int e0, v0;
      q0.delete(); q1.delete();
      e0 = err0; v0 = vcyc0;
      send_frame(32'hBA45FF00, 0, 1'b0, -1, 0, ok);
      n_chk++;
      if (q0.size() != 1 || q0[0] !== 32'hBA45FF00)
         $display("FAIL basic_data: got n=%0d d=%h want n=1 d=BA45FF00", q0.size(),
                  (q0.size() > 0) ? q0[0] : 32'h0);
      else n_pass++;
      n_chk++;
      if (vcyc0 - v0 !== 1) $display("FAIL basic_valid_cycles: got %0d want 1", vcyc0 - v0);
      else n_pass++;
      n_chk++;
      if (err0 !== e0) $display("FAIL basic_err: got %0d want %0d", err0, e0);
      else n_pass++;
      n_chk++;
      if (q1.size() != 1 || q1[0] !== 32'hBA45FF00)
         $display("FAIL basic_data_ac: got n=%0d want n=1", q1.size());
      else n_pass++;
   endtask

   task automatic test_bad_bit();
      bit ok;
      int e0, v0;
      q0.delete();
      e0 = err0; v0 = vcyc0;
      send_frame(32'hBA45FF00, 0, 1'b0, 20, 1200, ok);
      n_chk++;
      if (err0 - e0 !== (ok ? 0 : 1))
         $display("FAIL badbit_err: got %0d want %0d", err0 - e0, ok ? 0 : 1);
      else n_pass++;
      n_chk++;
      if (vcyc0 !== v0 || q0.size() != 0)
         $display("FAIL badbit_valid: got %0d valid cycles want 0", vcyc0 - v0);
      else n_pass++;
   endtask

   task automatic test_repeat();
      bit ok;
      int e0, r0;
      send_frame(32'hE11E2F00, 0, 1'b0, -1, 0, ok);
      e0 = err0; r0 = rep0;
      send_repeat();
`ifdef IR_REPEAT_EN
      n_chk++;
      if (rep0 - r0 !== 1 || err0 !== e0)
         $display("FAIL repeat_near: got rep=%0d err=%0d want rep=1 err=0", rep0 - r0, err0 - e0);
      else n_pass++;
`else
      n_chk++;
      if (rep0 - r0 !== 0 || err0 - e0 !== 1)
         $display("FAIL repeat_near: got rep=%0d err=%0d want rep=0 err=1", rep0 - r0, err0 - e0);
      else n_pass++;
`endif
      repeat (6000) @(negedge clk);
      e0 = err0; r0 = rep0;
      send_repeat();
`ifdef IR_REPEAT_EN
      n_chk++;
      if (rep0 - r0 !== 0 || err0 !== e0)
         $display("FAIL repeat_late: got rep=%0d err=%0d want rep=0 err=0", rep0 - r0, err0 - e0);
      else n_pass++;
`else
      n_chk++;
      if (rep0 - r0 !== 0 || err0 - e0 !== 1)
         $display("FAIL repeat_late: got rep=%0d err=%0d want rep=0 err=1", rep0 - r0, err0 - e0);
      else n_pass++;
`endif
   endtask

   task automatic test_overrun();
      bit ok;
      int o0;
      logic [31:0] wa, wb;
      logic [7:0] a, c;
      a = 8'($urandom); c = 8'($urandom);
      wa = {~c, c, ~a, a};
      wb = {c, ~c, a, ~a};
      q0.delete(); q1.delete();
      rdy = 1'b0;
      o0 = ovr0;
      send_frame(wa, 0, 1'b0, -1, 0, ok);
      n_chk++;
      if (bus0.oVALID !== 1'b1 || bus0.oDATA !== wa)
         $display("FAIL ovr_first: got v=%b d=%h want v=1 d=%h", bus0.oVALID, bus0.oDATA, wa);
      else n_pass++;
      send_frame(wb, 0, 1'b0, -1, 0, ok);
      n_chk++;
      if (ovr0 - o0 !== 1 || bus0.oDATA !== wa)
         $display("FAIL ovr_second: got ovr=%0d d=%h want ovr=1 d=%h", ovr0 - o0, bus0.oDATA, wa);
      else n_pass++;
      rdy = 1'b1;
      repeat (5) @(negedge clk);
      n_chk++;
      if (q0.size() != 1 || q0[0] !== wa || bus0.oVALID !== 1'b0)
         $display("FAIL ovr_consume: got n=%0d v=%b want n=1 v=0", q0.size(), bus0.oVALID);
      else n_pass++;
   endtask

   task automatic test_addr_chk();
      bit ok;
      int e1;
      q0.delete(); q1.delete();
      e1 = err1;
      send_frame(32'hBA450012, 0, 1'b0, -1, 0, ok);
      n_chk++;
      if (q0.size() != 1 || q0[0][15:0] !== 16'h0012)
         $display("FAIL addr_ext: got n=%0d want 1 frame with addr 0012", q0.size());
      else n_pass++;
      n_chk++;
      if (err1 - e1 !== 1 || q1.size() != 0)
         $display("FAIL addr_chk_err: got err=%0d n=%0d want err=1 n=0", err1 - e1, q1.size());
      else n_pass++;
   endtask

   task automatic test_midframe_reset();
      int e0, e1;
      q0.delete();
      e0 = err0; e1 = err1;
      seg(1'b0, 9000, 1'b0);
      seg(1'b1, 4500, 1'b0);
      for (int i = 0; i < 5; i++) begin
         seg(1'b0, 560, 1'b0);
         seg(1'b1, 1690, 1'b0);
      end
      seg(1'b0, 560, 1'b0);
      pin = 1'b1;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (17000) @(negedge clk);
      n_chk++;
      if (err0 !== e0 || err1 !== e1)
         $display("FAIL midreset_err: got %0d/%0d want 0/0", err0 - e0, err1 - e1);
      else n_pass++;
      n_chk++;
      if (bus0.oVALID !== 1'b0 || q0.size() != 0)
         $display("FAIL midreset_valid: got v=%b n=%0d want v=0 n=0", bus0.oVALID, q0.size());
      else n_pass++;
   endtask

   task automatic test_random();
      bit ok, x0, x1;
      int e0, e1;
      logic [7:0] a, ah, c, cn;
      logic [31:0] w;
      rdy = 1'b1;
      for (int k = 0; k < 4; k++) begin
         a  = 8'($urandom);
         ah = ($urandom_range(1, 0) == 0) ? ~a : 8'($urandom);
         c  = 8'($urandom);
         cn = ($urandom_range(2, 0) == 0) ? 8'($urandom) : ~c;
         w  = {cn, c, ah, a};
         q0.delete(); q1.delete();
         e0 = err0; e1 = err1;
         send_frame(w, 20, 1'b1, -1, 0, ok);
         x0 = ok && frame_ok(w, 1'b0);
         x1 = ok && frame_ok(w, 1'b1);
         n_chk++;
         if ((x0 && (q0.size() != 1 || q0[0] !== w || err0 !== e0)) ||
             (!x0 && (q0.size() != 0 || err0 - e0 !== 1)))
            $display("FAIL rand%0d_ext: w=%h got n=%0d err=%0d want ok=%b", k, w, q0.size(),
                     err0 - e0, x0);
         else n_pass++;
         n_chk++;
         if ((x1 && (q1.size() != 1 || q1[0] !== w || err1 !== e1)) ||
             (!x1 && (q1.size() != 0 || err1 - e1 !== 1)))
            $display("FAIL rand%0d_chk: w=%h got n=%0d err=%0d want ok=%b", k, w, q1.size(),
                     err1 - e1, x1);
         else n_pass++;
      end
   endtask

   initial begin
      rst = 1'b1;
      pin = 1'b1;
      rdy = 1'b1;
      test_reset();
      test_basic();
      test_bad_bit();
      test_repeat();
      test_overrun();
      test_addr_chk();
      test_midframe_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
